control_sequencer: RTL and testbench

CONTROL_SEQUENCER -- requirements
Module: control_sequencer

---
 rtl/control_sequencer_pkg.sv | 43 ++++
 rtl/control_sequencer_if.sv | 27 ++
 rtl/control_sequencer_reg_select_decoder.sv | 11 +
 rtl/control_sequencer.sv | 150 +++++++++++++++
 tb/tb_control_sequencer.sv | 164 ++++++++++++++++
 5 files changed

// File: rtl/control_sequencer_pkg.sv
// cpu_defs: shared definitions for the control sequencer.
//   - state_t      : 4-bit FSM state encoding
//   - OP_*         : supported opcodes
//   - *_HI/*_LO    : IR field bit positions
//   - is_three/is_unary : opcode class helpers
package cpu_defs;

  typedef enum logic [3:0] {
    S_IDLE = 4'd0,
    S_T0   = 4'd1,
    S_T1   = 4'd2,
    S_T2   = 4'd3,
    S_T3   = 4'd4,
    S_T4   = 4'd5,
    S_T5   = 4'd6
  } state_t;

  localparam logic [4:0] OP_ADD = 5'b00011;
  localparam logic [4:0] OP_SUB = 5'b00100;
  localparam logic [4:0] OP_AND = 5'b01010;
  localparam logic [4:0] OP_OR  = 5'b01011;
  localparam logic [4:0] OP_NEG = 5'b10001;
  localparam logic [4:0] OP_NOT = 5'b10010;
  localparam logic [4:0] OP_NOP = 5'b11010;

  localparam int OPC_HI = 31;
  localparam int OPC_LO = 27;
  localparam int RA_HI  = 26;
  localparam int RA_LO  = 23;
  localparam int RB_HI  = 22;
  localparam int RB_LO  = 19;
  localparam int RC_HI  = 18;
  localparam int RC_LO  = 15;

  function automatic logic is_three(input logic [4:0] op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) || (op == OP_OR);
  endfunction

  function automatic logic is_unary(input logic [4:0] op);
    return (op == OP_NEG) || (op == OP_NOT);
  endfunction

endpackage

// File: rtl/control_sequencer_if.sv
// Sequencer <-> datapath bundle.
//   run, ir, mem_ready : datapath -> sequencer
//   control strobes, reg_in/reg_out one-hots, alu_op, done, illegal :
//                        sequencer -> datapath
interface control_sequencer_if;
  logic        run;
  logic [31:0] ir;
  logic        mem_ready;
  logic        PCout, MARin, incPC, Zin, PCin, read, MDRin, MDRout, IRin, Yin, ZLowOut;
  logic [15:0] reg_in;
  logic [15:0] reg_out;
  logic [4:0]  alu_op;
  logic        done;
  logic        illegal;

  modport master (
    input  run, ir, mem_ready,
    output PCout, MARin, incPC, Zin, PCin, read, MDRin, MDRout, IRin, Yin, ZLowOut,
    output reg_in, reg_out, alu_op, done, illegal
  );

  modport slave (
    output run, ir, mem_ready,
    input  PCout, MARin, incPC, Zin, PCin, read, MDRin, MDRout, IRin, Yin, ZLowOut,
    input  reg_in, reg_out, alu_op, done, illegal
  );
endinterface

// File: rtl/control_sequencer_reg_select_decoder.sv
// reg_select_decoder: 4-bit register index + enable -> 16-bit one-hot select.
//   idx    : register number
//   en     : strobe enable; output is all-zero when low
//   onehot : R0..R15 select
module reg_select_decoder (
  input  logic [3:0]  idx,
  input  logic        en,
  output logic [15:0] onehot
);
  assign onehot = en ? (16'd1 << idx) : 16'd0;
endmodule

// File: rtl/control_sequencer.sv
// control_sequencer: multi-cycle fetch/decode/execute controller.
//   clock : rising-edge clock
//   clear : synchronous active-high reset
//   bus   : datapath bundle (master side) - run/ir/mem_ready in,
//           control strobes, register selects, alu_op, done, illegal out
// Outputs are decoded combinationally from the state, the IR and mem_ready.
module control_sequencer
  import cpu_defs::*;
(
  input  logic               clock,
  input  logic               clear,
  control_sequencer_if.master bus
);

  state_t     state, nxt;
  logic [4:0] op;
  logic [3:0] ra, rb, rc;
  logic [3:0] out_idx;
  logic       in_en, out_en;
  logic       unused_ir;

  assign op = bus.ir[OPC_HI:OPC_LO];
  assign ra = bus.ir[RA_HI:RA_LO];
  assign rb = bus.ir[RB_HI:RB_LO];
  assign rc = bus.ir[RC_HI:RC_LO];
  assign unused_ir = ^bus.ir[RC_LO-1:0];

  always_ff @(posedge clock) begin
    if (clear) state <= S_IDLE;
    else       state <= nxt;
  end

  always_comb begin
    nxt         = state;
    bus.PCout   = 1'b0;
    bus.MARin   = 1'b0;
    bus.incPC   = 1'b0;
    bus.Zin     = 1'b0;
    bus.PCin    = 1'b0;
    bus.read    = 1'b0;
    bus.MDRin   = 1'b0;
    bus.MDRout  = 1'b0;
    bus.IRin    = 1'b0;
    bus.Yin     = 1'b0;
    bus.ZLowOut = 1'b0;
    bus.alu_op  = 5'd0;
    bus.done    = 1'b0;
    bus.illegal = 1'b0;
    in_en       = 1'b0;
    out_en      = 1'b0;
    out_idx     = rb;

    case (state)
      S_IDLE: if (bus.run) nxt = S_T0;
      S_T0: begin
        bus.PCout = 1'b1;
        bus.MARin = 1'b1;
        bus.incPC = 1'b1;
        bus.Zin   = 1'b1;
        nxt       = S_T1;
      end
      S_T1: begin
        bus.read  = 1'b1;
        bus.MDRin = 1'b1;
        // Incremented PC sits in Z; commit it only once the fetch completes.
        if (bus.mem_ready) begin
          bus.ZLowOut = 1'b1;
          bus.PCin    = 1'b1;
          nxt         = S_T2;
        end
      end
      S_T2: begin
        bus.MDRout = 1'b1;
        bus.IRin   = 1'b1;
        nxt        = S_T3;
      end
      S_T3: begin
        if (is_three(op)) begin
          out_en  = 1'b1;
          bus.Yin = 1'b1;
          nxt     = S_T4;
        end else if (is_unary(op)) begin
          out_en     = 1'b1;
          bus.alu_op = op;
          bus.Zin    = 1'b1;
          nxt        = S_T4;
        end else begin
          // NOP and unsupported opcodes retire here with no strobes.
          bus.done    = 1'b1;
          bus.illegal = (op != OP_NOP);
          nxt         = bus.run ? S_T0 : S_IDLE;
        end
      end
      S_T4: begin
        if (is_three(op)) begin
          out_en     = 1'b1;
          out_idx    = rc;
          bus.alu_op = op;
          bus.Zin    = 1'b1;
          nxt        = S_T5;
        end else begin
          bus.ZLowOut = 1'b1;
          in_en       = 1'b1;
          bus.done    = 1'b1;
          nxt         = bus.run ? S_T0 : S_IDLE;
        end
      end
      S_T5: begin
        bus.ZLowOut = 1'b1;
        in_en       = 1'b1;
        bus.done    = 1'b1;
        nxt         = bus.run ? S_T0 : S_IDLE;
      end
      default: nxt = S_IDLE;
    endcase

    // Quiet the datapath while clear is held, even before the first edge.
    if (clear) begin
      bus.PCout   = 1'b0;
      bus.MARin   = 1'b0;
      bus.incPC   = 1'b0;
      bus.Zin     = 1'b0;
      bus.PCin    = 1'b0;
      bus.read    = 1'b0;
      bus.MDRin   = 1'b0;
      bus.MDRout  = 1'b0;
      bus.IRin    = 1'b0;
      bus.Yin     = 1'b0;
      bus.ZLowOut = 1'b0;
      bus.alu_op  = 5'd0;
      bus.done    = 1'b0;
      bus.illegal = 1'b0;
      in_en       = 1'b0;
      out_en      = 1'b0;
    end
  end

  reg_select_decoder u_in_dec (
    .idx    (ra),
    .en     (in_en),
    .onehot (bus.reg_in)
  );

  reg_select_decoder u_out_dec (
    .idx    (out_idx),
    .en     (out_en),
    .onehot (bus.reg_out)
  );

endmodule

// File: tb/tb_control_sequencer.sv
module tb_control_sequencer;

  logic clock = 1'b0;
  logic clear;
  control_sequencer_if bus ();

  control_sequencer dut (
    .clock (clock),
    .clear (clear),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  // Strobe packing: {PCout,MARin,incPC,Zin,PCin,read,MDRin,MDRout,IRin,Yin,ZLowOut}
  localparam logic [10:0] C_NONE = 11'b000_0000_0000;
  localparam logic [10:0] C_T0   = 11'b111_1000_0000;
  localparam logic [10:0] C_T1W  = 11'b000_0011_0000;
  localparam logic [10:0] C_T1R  = 11'b000_0111_0001;
  localparam logic [10:0] C_T2   = 11'b000_0000_1100;
  localparam logic [10:0] C_Y    = 11'b000_0000_0010;
  localparam logic [10:0] C_Z    = 11'b000_1000_0000;
  localparam logic [10:0] C_ZL   = 11'b000_0000_0001;

  typedef struct {
    logic        clr, run, mr;
    logic [31:0] ir;
    logic [10:0] ctl;
    logic [15:0] rin, rout;
    logic [4:0]  alu;
    logic        dn, il;
  } vec_t;

  vec_t vq[$];
  int   tests = 0;
  int   fails = 0;
  int   step_no = 0;

  logic [10:0] act_ctl;
  assign act_ctl = {bus.PCout, bus.MARin, bus.incPC, bus.Zin, bus.PCin, bus.read,
                    bus.MDRin, bus.MDRout, bus.IRin, bus.Yin, bus.ZLowOut};

  function automatic logic [31:0] mk_ir(input logic [4:0] op, input logic [3:0] a,
                                        input logic [3:0] b, input logic [3:0] c);
    return {op, a, b, c, 15'h0};
  endfunction

  function automatic vec_t v(input logic clr, input logic run, input logic mr,
                             input logic [31:0] ir, input logic [10:0] ctl,
                             input logic [15:0] rin, input logic [15:0] rout,
                             input logic [4:0] alu, input logic dn, input logic il);
    vec_t r;
    r.clr = clr; r.run = run; r.mr = mr; r.ir = ir; r.ctl = ctl;
    r.rin = rin; r.rout = rout; r.alu = alu; r.dn = dn; r.il = il;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL step %0d %s: got 0x%0h expected 0x%0h", step_no, name, act, exp);
    end
  endtask

  // Drive one cycle's inputs, check outputs mid-cycle, then advance past the edge.
  task automatic step(input vec_t t);
    clear         = t.clr;
    bus.run       = t.run;
    bus.mem_ready = t.mr;
    bus.ir        = t.ir;
    @(negedge clock);
    chk("ctl",     32'(act_ctl),     32'(t.ctl));
    chk("reg_in",  32'(bus.reg_in),  32'(t.rin));
    chk("reg_out", 32'(bus.reg_out), 32'(t.rout));
    chk("alu_op",  32'(bus.alu_op),  32'(t.alu));
    chk("done",    32'(bus.done),    32'(t.dn));
    chk("illegal", 32'(bus.illegal), 32'(t.il));
    @(posedge clock);
    #1;
    step_no++;
  endtask

  logic [31:0] add1, add2, neg1, ill1, nop1, not1;

  initial begin
    clear = 1'b1; bus.run = 1'b0; bus.mem_ready = 1'b0; bus.ir = '0;
    add1 = mk_ir(5'b00011, 4'd4, 4'd3, 4'd7);
    add2 = mk_ir(5'b00011, 4'd1, 4'd1, 4'd1);
    neg1 = mk_ir(5'b10001, 4'd5, 4'd0, 4'd0);
    ill1 = mk_ir(5'b11111, 4'd2, 4'd3, 4'd4);
    nop1 = mk_ir(5'b11010, 4'd6, 4'd7, 4'd8);
    not1 = mk_ir(5'b10010, 4'd2, 4'd9, 4'd0);

    // clear with run high, then IDLE -> T0
    vq.push_back(v(1, 1, 1, add1, C_NONE, 16'h0, 16'h0, 5'd0, 0, 0));
    vq.push_back(v(0, 1, 1, add1, C_NONE, 16'h0, 16'h0, 5'd0, 0, 0));
    // ADD R4,R3,R7
    vq.push_back(v(0, 1, 1, add1, C_T0,   16'h0,    16'h0,    5'd0,  0, 0));
    vq.push_back(v(0, 1, 1, add1, C_T1R,  16'h0,    16'h0,    5'd0,  0, 0));
    vq.push_back(v(0, 1, 1, add1, C_T2,   16'h0,    16'h0,    5'd0,  0, 0));
    vq.push_back(v(0, 1, 1, add1, C_Y,    16'h0,    16'h0008, 5'd0,  0, 0));
    vq.push_back(v(0, 1, 1, add1, C_Z,    16'h0,    16'h0080, 5'd3,  0, 0));
    vq.push_back(v(0, 1, 1, add1, C_ZL,   16'h0010, 16'h0,    5'd0,  1, 0));
    // ADD R1,R1,R1 back-to-back
    vq.push_back(v(0, 1, 1, add2, C_T0,   16'h0,    16'h0,    5'd0,  0, 0));
    vq.push_back(v(0, 1, 1, add2, C_T1R,  16'h0,    16'h0,    5'd0,  0, 0));
    vq.push_back(v(0, 1, 1, add2, C_T2,   16'h0,    16'h0,    5'd0,  0, 0));
    vq.push_back(v(0, 1, 1, add2, C_Y,    16'h0,    16'h0002, 5'd0,  0, 0));
    vq.push_back(v(0, 1, 1, add2, C_Z,    16'h0,    16'h0002, 5'd3,  0, 0));
    vq.push_back(v(0, 1, 1, add2, C_ZL,   16'h0002, 16'h0,    5'd0,  1, 0));
    // NEG R5,R0; run drops mid-instruction, finishes, then IDLE
    vq.push_back(v(0, 1, 1, neg1, C_T0,   16'h0,    16'h0,    5'd0,  0, 0));
    vq.push_back(v(0, 0, 1, neg1, C_T1R,  16'h0,    16'h0,    5'd0,  0, 0));
    vq.push_back(v(0, 0, 1, neg1, C_T2,   16'h0,    16'h0,    5'd0,  0, 0));
    vq.push_back(v(0, 0, 1, neg1, C_Z,    16'h0,    16'h0001, 5'd17, 0, 0));
    vq.push_back(v(0, 0, 1, neg1, C_ZL,   16'h0020, 16'h0,    5'd0,  1, 0));
    vq.push_back(v(0, 1, 1, ill1, C_NONE, 16'h0,    16'h0,    5'd0,  0, 0));
    // opcode 11111
    vq.push_back(v(0, 1, 1, ill1, C_T0,   16'h0,    16'h0,    5'd0,  0, 0));
    vq.push_back(v(0, 1, 1, ill1, C_T1R,  16'h0,    16'h0,    5'd0,  0, 0));
    vq.push_back(v(0, 1, 1, ill1, C_T2,   16'h0,    16'h0,    5'd0,  0, 0));
    vq.push_back(v(0, 1, 1, ill1, C_NONE, 16'h0,    16'h0,    5'd0,  1, 1));
    // NOP
    vq.push_back(v(0, 1, 1, nop1, C_T0,   16'h0,    16'h0,    5'd0,  0, 0));
    vq.push_back(v(0, 1, 1, nop1, C_T1R,  16'h0,    16'h0,    5'd0,  0, 0));
    vq.push_back(v(0, 1, 1, nop1, C_T2,   16'h0,    16'h0,    5'd0,  0, 0));
    vq.push_back(v(0, 1, 1, nop1, C_NONE, 16'h0,    16'h0,    5'd0,  1, 0));
    // NOT R2,R9
    vq.push_back(v(0, 1, 1, not1, C_T0,   16'h0,    16'h0,    5'd0,  0, 0));
    vq.push_back(v(0, 1, 1, not1, C_T1R,  16'h0,    16'h0,    5'd0,  0, 0));
    vq.push_back(v(0, 1, 1, not1, C_T2,   16'h0,    16'h0,    5'd0,  0, 0));
    vq.push_back(v(0, 1, 1, not1, C_Z,    16'h0,    16'h0200, 5'd18, 0, 0));
    vq.push_back(v(0, 0, 1, not1, C_ZL,   16'h0004, 16'h0,    5'd0,  1, 0));
    vq.push_back(v(0, 0, 1, not1, C_NONE, 16'h0,    16'h0,    5'd0,  0, 0));
    vq.push_back(v(0, 0, 1, not1, C_NONE, 16'h0,    16'h0,    5'd0,  0, 0));

    @(posedge clock); #1;
    for (int i = 0; i < vq.size(); i++) step(vq[i]);

    // memory stall: three wait cycles in T1, PCin only on the fourth
    step(v(0, 1, 0, add1, C_NONE, 16'h0, 16'h0, 5'd0, 0, 0));
    step(v(0, 1, 0, add1, C_T0,   16'h0, 16'h0, 5'd0, 0, 0));
    for (int i = 0; i < 3; i++)
      step(v(0, 1, 0, add1, C_T1W, 16'h0, 16'h0, 5'd0, 0, 0));
    step(v(0, 1, 1, add1, C_T1R,  16'h0,    16'h0,    5'd0, 0, 0));
    step(v(0, 1, 1, add1, C_T2,   16'h0,    16'h0,    5'd0, 0, 0));
    step(v(0, 1, 1, add1, C_Y,    16'h0,    16'h0008, 5'd0, 0, 0));
    step(v(0, 1, 1, add1, C_Z,    16'h0,    16'h0080, 5'd3, 0, 0));
    step(v(0, 0, 1, add1, C_ZL,   16'h0010, 16'h0,    5'd0, 1, 0));

    // clear during T1 wait: back to IDLE, nothing strobes, no done
    step(v(0, 1, 0, add1, C_NONE, 16'h0, 16'h0, 5'd0, 0, 0));
    step(v(0, 1, 0, add1, C_T0,   16'h0, 16'h0, 5'd0, 0, 0));
    step(v(0, 1, 0, add1, C_T1W,  16'h0, 16'h0, 5'd0, 0, 0));
    step(v(1, 1, 0, add1, C_NONE, 16'h0, 16'h0, 5'd0, 0, 0));
    step(v(0, 0, 1, add1, C_NONE, 16'h0, 16'h0, 5'd0, 0, 0));
    step(v(0, 0, 1, add1, C_NONE, 16'h0, 16'h0, 5'd0, 0, 0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
